// File: rtl/hilo_pkg.sv
// Shared constants, state encoding and helpers for the sequential HI/LO multiply/divide unit.
package hilo_pkg;

  localparam int unsigned ITER = 32;

  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  function automatic logic is_muldiv(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Combinational single step: shift-add multiply or restoring-divide subtract-shift.
module muldiv_iter (
  input  logic        op_div_i,
  input  logic [63:0] acc_i,
  input  logic [31:0] operand_i,
  output logic [63:0] acc_o
);

  logic [32:0] sum;
  logic [32:0] trial;

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}, LSB consumed each step.
    sum   = {1'b0, acc_i[63:32]} + {1'b0, (acc_i[0] ? operand_i : 32'd0)};
    // Divide: acc = {remainder, quotient}; the shifted remainder needs 33 bits.
    trial = acc_i[63:31] - {1'b0, operand_i};
    if (op_div_i) begin
      if (!trial[32]) begin
        acc_o = {trial[31:0], acc_i[30:0], 1'b1};
      end else begin
        acc_o = {acc_i[62:0], 1'b0};
      end
    end else begin
      acc_o = {sum, acc_i[31:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register file with a 32-iteration sequential multiplier/divider and busy/done handshake.
module hilo_muldiv_unit #(
  parameter int unsigned ITER = hilo_pkg::ITER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  functcode,
  input  logic [31:0] rs_content,
  input  logic [31:0] rt_content,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  import hilo_pkg::*;

  localparam int unsigned CntW = $clog2(ITER + 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            is_div_q;
  logic            neg_quot_q;
  logic            neg_rem_q;
  logic            div0_q;
  logic [31:0]     rs_q;
  logic [31:0]     opnd_q;
  logic [63:0]     acc_q;
  logic [31:0]     hi_q;
  logic [31:0]     lo_q;
  logic            busy_q;
  logic            done_q;

  logic            signed_op;
  logic [31:0]     rs_mag;
  logic [31:0]     rt_mag;
  logic [63:0]     acc_step;
  logic [63:0]     prod_fix;
  logic [31:0]     quot_fix;
  logic [31:0]     rem_fix;

  always_comb begin
    signed_op = (functcode == FN_MULT) || (functcode == FN_DIV);
    rs_mag    = signed_op ? abs32(rs_content) : rs_content;
    rt_mag    = signed_op ? abs32(rt_content) : rt_content;
    // neg_* are only ever set for signed ops, so they alone decide the sign fix-up.
    prod_fix  = neg_quot_q ? (~acc_q + 64'd1) : acc_q;
    quot_fix  = neg_quot_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix   = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
  end

  muldiv_iter u_iter (
    .op_div_i  (is_div_q),
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .acc_o     (acc_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
      rs_q       <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_muldiv(functcode)) begin
              state_q    <= RUN;
              busy_q     <= 1'b1;
              cnt_q      <= '0;
              is_div_q   <= functcode[1];
              neg_quot_q <= signed_op & (rs_content[31] ^ rt_content[31]);
              neg_rem_q  <= signed_op & rs_content[31];
              div0_q     <= (rt_content == 32'd0);
              rs_q       <= rs_content;
              opnd_q     <= rt_mag;
              acc_q      <= {32'd0, rs_mag};
            end else if (functcode == FN_MTHI) begin
              hi_q <= rs_content;
            end else if (functcode == FN_MTLO) begin
              lo_q <= rs_content;
            end
          end
        end
        RUN: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(ITER - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          cnt_q   <= '0;
          if (!is_div_q) begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end else if (div0_q) begin
            hi_q <= rs_q;
            lo_q <= 32'hFFFF_FFFF;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: arithmetic reference model plus literal checks.
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  functcode;
  logic [31:0] rs_content;
  logic [31:0] rt_content;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  hilo_muldiv_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .functcode  (functcode),
    .rs_content (rs_content),
    .rt_content (rt_content),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model_result(input logic [5:0] fn, input logic [31:0] a,
                                               input logic [31:0] b);
    longint sa, sb;
    int ia, ib;
    logic [63:0] r;
    r = '0;
    case (fn)
      FN_MULTU: r = {32'd0, a} * {32'd0, b};
      FN_MULT: begin
        sa = $signed(a);
        sb = $signed(b);
        r  = sa * sb;
      end
      FN_DIVU: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else            r = {a % b, a / b};
      end
      FN_DIV: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else begin
          ia = a;
          ib = b;
          r  = {32'(ia % ib), 32'(ia / ib)};
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [31:0] m_hi, m_lo;
  logic        m_busy, m_done;
  logic [63:0] m_res;
  int          m_left = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = m_res[63:32]; m_lo = m_res[31:0]; m_busy = 1'b0; m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        if (is_muldiv(functcode)) begin
          m_res  = model_result(functcode, rs_content, rt_content);
          m_left = 33;
          m_busy = 1'b1;
        end else if (functcode == FN_MTHI) m_hi = rs_content;
        else if (functcode == FN_MTLO)     m_lo = rs_content;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model busy", 64'(busy), 64'(m_busy));
      check("model done", 64'(done), 64'(m_done));
      check("model hi", 64'(hi), 64'(m_hi));
      check("model lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; functcode = fn; rs_content = a; rt_content = b;
    @(negedge clk);
    start = 1'b0; functcode = 6'h00;
  endtask

  task automatic wait_done(input int elapsed, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input string name);
    int n;
    n = elapsed;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, 64'(n), 64'd33);
    check({name, " hi"}, 64'(hi), 64'(exp_hi));
    check({name, " lo"}, 64'(lo), 64'(exp_lo));
    check({name, " busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; functcode = '0; rs_content = '0; rt_content = '0;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);

    issue(FN_MULT, 32'hFFFF_FFFF, 32'd2);
    wait_done(0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult -1*2");
    @(negedge clk);
    issue(FN_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_done(0, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
    @(negedge clk);
    issue(FN_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2");
    @(negedge clk);
    issue(FN_DIVU, 32'd100, 32'd7);
    wait_done(0, 32'd2, 32'd14, "divu 100/7");
    @(negedge clk);
    issue(FN_DIVU, 32'd5, 32'd0);
    wait_done(0, 32'd5, 32'hFFFF_FFFF, "divu by zero");
    @(negedge clk);
    issue(FN_DIV, 32'hFFFF_FFFB, 32'd0);
    wait_done(0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div -5 by zero");
    @(negedge clk);
    issue(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, 32'd0, 32'h8000_0000, "div overflow");
    @(negedge clk);

    // MTHI then MTLO on consecutive edges.
    start = 1'b1; functcode = FN_MTHI; rs_content = 32'h1234_5678;
    @(negedge clk);
    check("mthi hi", 64'(hi), 64'h1234_5678);
    functcode = FN_MTLO; rs_content = 32'hCAFE_BABE;
    @(negedge clk);
    start = 1'b0;
    check("mtlo lo", 64'(lo), 64'hCAFE_BABE);
    check("mtlo hi kept", 64'(hi), 64'h1234_5678);
    check("mtlo busy", 64'(busy), 64'd0);
    check("mtlo done", 64'(done), 64'd0);

    // MTLO while a DIV is in flight must be ignored.
    issue(FN_DIV, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; functcode = FN_MTLO; rs_content = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, 32'd2, 32'd14, "div with mtlo");
    @(negedge clk);

    // Reset mid-MULTU aborts with no partial result.
    issue(FN_MULTU, 32'h0000_1234, 32'h0000_5678);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    repeat (40) @(negedge clk);

    // Undefined functcode changes nothing.
    issue(6'h20, 32'h5555_5555, 32'd3);
    check("undef hi", 64'(hi), 64'd0);
    check("undef busy", 64'(busy), 64'd0);

    issue(FN_DIVU, 32'd1000, 32'd3);
    wait_done(0, 32'd1, 32'd333, "divu after abort");
    @(negedge clk);

    // Back-to-back: second op issued while done is high.
    issue(FN_MULT, 32'd7, 32'hFFFF_FFFD);
    wait_done(0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult 7*-3");
    issue(FN_MULT, 32'h8000_0000, 32'h8000_0000);
    check("b2b busy", 64'(busy), 64'd1);
    wait_done(0, 32'h4000_0000, 32'd0, "b2b mult");
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
